// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite write responder: B response codes and
// the response-channel state encoding.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry holding register with load/clear and a full flag; only the flag is
// reset, the payload is simply overwritten on every load.
module axil_hold_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         full,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b1;
      end else if (clear) begin
         full <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/axil_wr_responder.sv
// AXI4-Lite write responder: pairs AW and W beats, issues one register write
// and one B response per pair. Optional range check: AXIL_WR_RESP_SLVERR_EN.
module axil_wr_responder
   import axil_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int REG_NUM = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [ADDR_W-1:0]     s_awaddr,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic [DATA_W/8-1:0]   s_wstrb,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   output logic [1:0]            s_bresp,
   output logic                  reg_wr_en,
   output logic [ADDR_W-3:0]     reg_wr_addr,
   output logic [DATA_W-1:0]     reg_wr_data,
   output logic [DATA_W/8-1:0]   reg_wr_strb
);

   localparam int STRB_W = DATA_W / 8;
   localparam int WH_W   = DATA_W + STRB_W;

   logic              init_done;
   logic              aw_full;
   logic              w_full;
   logic              aw_load;
   logic              w_load;
   logic              commit;
   logic              cmd_err;
   logic [ADDR_W-1:0] aw_addr;
   logic [WH_W-1:0]   w_hold;
   state_t            state;
   state_t            state_nxt;

   // Readies stay low for one cycle after reset release so a beat presented
   // right at release is not accepted before the holders are known empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_done <= 1'b0;
      end else begin
         init_done <= 1'b1;
      end
   end

   assign s_awready = ~aw_full & init_done;
   assign s_wready  = ~w_full & init_done;
   assign aw_load   = s_awvalid & s_awready;
   assign w_load    = s_wvalid & s_wready;

   axil_hold_reg #(.W(ADDR_W)) u_aw_hold (
      .clk   (clk),
      .rst   (rst),
      .load  (aw_load),
      .clear (commit),
      .d     (s_awaddr),
      .full  (aw_full),
      .q     (aw_addr)
   );

   axil_hold_reg #(.W(WH_W)) u_w_hold (
      .clk   (clk),
      .rst   (rst),
      .load  (w_load),
      .clear (commit),
      .d     ({s_wdata, s_wstrb}),
      .full  (w_full),
      .q     (w_hold)
   );

   // Byte offset within the word is ignored; only the word index is used.
   logic unused_addr_bits;
   assign unused_addr_bits = ^aw_addr[1:0];

`ifdef AXIL_WR_RESP_SLVERR_EN
   assign cmd_err = (32'(aw_addr[ADDR_W-1:2]) >= $unsigned(REG_NUM));
`else
   localparam int unused_reg_num = REG_NUM;
   assign cmd_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A new pair may commit while a B is outstanding only if that B is being
   // taken this cycle, giving back-to-back responses without a bubble.
   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      if (aw_full && w_full && (state == IDLE || s_bready)) begin
         commit = 1'b1;
      end
      case (state)
         IDLE: begin
            if (commit) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (s_bready && !commit) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign s_bvalid = (state == RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_wr_en   <= 1'b0;
         reg_wr_addr <= '0;
         reg_wr_data <= '0;
         reg_wr_strb <= '0;
         s_bresp     <= RESP_OKAY;
      end else begin
         reg_wr_en <= 1'b0;
         if (commit) begin
            reg_wr_en   <= ~cmd_err;
            reg_wr_addr <= aw_addr[ADDR_W-1:2];
            reg_wr_data <= w_hold[WH_W-1:STRB_W];
            reg_wr_strb <= w_hold[STRB_W-1:0];
            s_bresp     <= cmd_err ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

endmodule

// File: tb/tb_axil_wr_responder.sv
`define CHK(tag, obs, exp) \
  begin \
    n_chk++; \
    assert ((obs) === (exp)) n_pass++; \
    else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
    end \
  end

module tb_axil_wr_responder;

  typedef struct {
    int          cyc;
    logic [9:0]  idx;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct {
    int         cyc;
    logic [1:0] resp;
  } b_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [11:0] s_awaddr = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [1:0]  s_bresp;
  logic        reg_wr_en;
  logic [9:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  wr_t        got_wr[$];
  wr_t        exp_wr[$];
  b_t         got_b[$];
  logic [1:0] exp_b[$];

  axil_wr_responder #(.ADDR_W(12), .DATA_W(32), .REG_NUM(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_awvalid   (s_awvalid),
    .s_awready   (s_awready),
    .s_awaddr    (s_awaddr),
    .s_wvalid    (s_wvalid),
    .s_wready    (s_wready),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .s_bresp     (s_bresp),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_strb (reg_wr_strb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr_en) got_wr.push_back('{cyc, reg_wr_addr, reg_wr_data, reg_wr_strb});
      if (s_bvalid && s_bready) got_b.push_back('{cyc, s_bresp});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] model_resp(input logic [11:0] a);
`ifdef AXIL_WR_RESP_SLVERR_EN
    return (int'(a[11:2]) >= 16) ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  task automatic push_exp(input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit with_b);
    logic [1:0] r;
    r = model_resp(a);
    if (r == 2'b00) exp_wr.push_back('{0, a[11:2], d, s});
    if (with_b) exp_b.push_back(r);
  endtask

  task automatic send_aw(input logic [11:0] a, input int dly, output int hc, output bit ok);
    hc = -1;
    ok = 1'b0;
    if (dly > 0) begin
      repeat (dly) @(posedge clk);
      #1;
    end
    s_awaddr  = a;
    s_awvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_awready) begin
        hc = cyc;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly,
                        output int hc, output bit ok);
    hc = -1;
    ok = 1'b0;
    if (dly > 0) begin
      repeat (dly) @(posedge clk);
      #1;
    end
    s_wdata  = d;
    s_wstrb  = s;
    s_wvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_wready) begin
        hc = cyc;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_wvalid = 1'b0;
  endtask

  task automatic send_pair(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input bit with_b,
                           output int hca, output int hcw);
    bit oka;
    bit okw;
    int ha;
    int hw;
    fork
      send_aw(a, awd, ha, oka);
      send_w(d, s, wd, hw, okw);
    join
    hca = ha;
    hcw = hw;
    `CHK("aw_handshake", oka, 1'b1)
    `CHK("w_handshake", okw, 1'b1)
    push_exp(a, d, s, with_b);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_queues();
    `CHK("wr_count", got_wr.size(), exp_wr.size())
    `CHK("b_count", got_b.size(), exp_b.size())
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      n_chk++;
      if (got_wr[i].idx === exp_wr[i].idx) n_pass++;
      else begin
        n_fail++;
        $error("FAIL wr_idx: observed %0h expected %0h", got_wr[i].idx, exp_wr[i].idx);
      end
      n_chk++;
      if (got_wr[i].data === exp_wr[i].data) n_pass++;
      else begin
        n_fail++;
        $error("FAIL wr_data: observed %0h expected %0h", got_wr[i].data, exp_wr[i].data);
      end
      n_chk++;
      if (got_wr[i].strb === exp_wr[i].strb) n_pass++;
      else begin
        n_fail++;
        $error("FAIL wr_strb: observed %0h expected %0h", got_wr[i].strb, exp_wr[i].strb);
      end
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      n_chk++;
      if (got_b[i].resp === exp_b[i]) n_pass++;
      else begin
        n_fail++;
        $error("FAIL b_resp: observed %0h expected %0h", got_b[i].resp, exp_b[i]);
      end
    end
    got_wr.delete();
    exp_wr.delete();
    got_b.delete();
    exp_b.delete();
  endtask

  initial begin
    int          hca;
    int          hcw;
    int          rc;
    int          first_cyc;
    bit          ok;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;

    repeat (2) @(negedge clk);
    #1;
    `CHK("rst_awready", s_awready, 1'b0)
    `CHK("rst_wready", s_wready, 1'b0)
    `CHK("rst_bvalid", s_bvalid, 1'b0)
    `CHK("rst_bresp", s_bresp, 2'b00)
    `CHK("rst_wr_en", reg_wr_en, 1'b0)
    `CHK("rst_wr_addr", reg_wr_addr, 10'd0)
    `CHK("rst_wr_data", reg_wr_data, 32'd0)
    `CHK("rst_wr_strb", reg_wr_strb, 4'd0)
    rst = 1'b0;
    #1;
    `CHK("init_awready_low", s_awready, 1'b0)
    @(negedge clk);
    `CHK("init_awready_high", s_awready, 1'b1)
    `CHK("init_wready_high", s_wready, 1'b1)
    @(posedge clk);
    #1;

    s_bready = 1'b1;
    send_pair(12'h008, 32'hDEADBEEF, 4'hF, 0, 0, 1'b1, hca, hcw);
    `CHK("t1_same_cycle", hcw, hca)
    `CHK("t1_awready_full", s_awready, 1'b0)
    `CHK("t1_wready_full", s_wready, 1'b0)
    @(posedge clk);
    #1;
    `CHK("t1_wr_en", reg_wr_en, 1'b1)
    `CHK("t1_bvalid", s_bvalid, 1'b1)
    `CHK("t1_awready_again", s_awready, 1'b1)
    `CHK("t1_wready_again", s_wready, 1'b1)
    drain();
    `CHK("t1_bvalid_drop", s_bvalid, 1'b0)
    first_cyc = (got_wr.size() > 0) ? got_wr[0].cyc : -1;
    `CHK("t1_wr_latency", first_cyc, hca + 2)
    first_cyc = (got_b.size() > 0) ? got_b[0].cyc : -1;
    `CHK("t1_b_latency", first_cyc, hca + 2)
    check_queues();

    send_w(32'h12345678, 4'h3, 0, hcw, ok);
    `CHK("t2_w_handshake", ok, 1'b1)
    `CHK("t2_wready_held", s_wready, 1'b0)
    send_aw(12'h004, 2, hca, ok);
    `CHK("t2_aw_handshake", ok, 1'b1)
    `CHK("t2_skew", hca - hcw, 3)
    push_exp(12'h004, 32'h12345678, 4'h3, 1'b1);
    drain();
    first_cyc = (got_wr.size() > 0) ? got_wr[0].cyc : -1;
    `CHK("t2_wr_latency", first_cyc, hca + 2)
    check_queues();

    s_bready = 1'b0;
    send_pair(12'h00C, 32'hA5A5_0001, 4'hF, 0, 0, 1'b1, hca, hcw);
    send_pair(12'h010, 32'hA5A5_0002, 4'h9, 1, 0, 1'b1, hca, hcw);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (s_awready === 1'b0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL t3_awready_stall: observed %0h", s_awready);
      end
      n_chk++;
      if (s_wready === 1'b0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL t3_wready_stall: observed %0h", s_wready);
      end
      n_chk++;
      if (s_bvalid === 1'b1) n_pass++;
      else begin
        n_fail++;
        $error("FAIL t3_bvalid_hold: observed %0h", s_bvalid);
      end
      n_chk++;
      if (s_bresp === 2'b00) n_pass++;
      else begin
        n_fail++;
        $error("FAIL t3_bresp_hold: observed %0h", s_bresp);
      end
    end
    `CHK("t3_one_write_held", got_wr.size(), 1)
    @(posedge clk);
    #1;
    s_bready = 1'b1;
    rc = cyc;
    drain();
    first_cyc = (got_wr.size() > 1) ? got_wr[1].cyc : -1;
    `CHK("t3_second_wr_cycle", first_cyc, rc + 1)
    check_queues();

    send_pair(12'h040, 32'hCAFE_F00D, 4'hF, 0, 0, 1'b1, hca, hcw);
    drain();
    check_queues();

    for (int n = 0; n < 20; n++) begin
      a = {6'd0, 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 1) << 3), 2'($urandom)};
      a[11:8] = 4'd0;
      a[7:2]  = 6'($urandom_range(0, 20));
      d = $urandom;
      s = 4'($urandom);
      send_pair(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, hca, hcw);
    end
    drain();
    check_queues();

    s_bready = 1'b0;
    send_pair(12'h018, 32'h0BAD_0001, 4'hF, 0, 0, 1'b0, hca, hcw);
    send_aw(12'h01C, 0, hca, ok);
    `CHK("t6_aw_held", ok, 1'b1)
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    `CHK("t6_async_bvalid", s_bvalid, 1'b0)
    `CHK("t6_async_awready", s_awready, 1'b0)
    `CHK("t6_async_wready", s_wready, 1'b0)
    `CHK("t6_async_bresp", s_bresp, 2'b00)
    `CHK("t6_async_wr_en", reg_wr_en, 1'b0)
    `CHK("t6_async_wr_addr", reg_wr_addr, 10'd0)
    `CHK("t6_async_wr_data", reg_wr_data, 32'd0)
    `CHK("t6_async_wr_strb", reg_wr_strb, 4'd0)
    @(negedge clk);
    rst = 1'b0;
    s_bready = 1'b1;
    #1;
    `CHK("t6_rel_awready_low", s_awready, 1'b0)
    @(negedge clk);
    `CHK("t6_rel_awready_high", s_awready, 1'b1)
    `CHK("t6_rel_wready_high", s_wready, 1'b1)
    `CHK("t6_rel_bvalid", s_bvalid, 1'b0)
    @(posedge clk);
    #1;
    send_w(32'h0BAD_0002, 4'h6, 0, hcw, ok);
    `CHK("t6_w_handshake", ok, 1'b1)
    repeat (4) @(posedge clk);
    #1;
    `CHK("t6_no_wr_after_rst", got_wr.size(), exp_wr.size())
    `CHK("t6_no_b_after_rst", got_b.size(), 0)
    send_aw(12'h020, 0, hca, ok);
    `CHK("t6_aw_handshake", ok, 1'b1)
    push_exp(12'h020, 32'h0BAD_0002, 4'h6, 1'b1);
    drain();
    check_queues();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axil_wr_responder.md
# axil_wr_responder

AXI4-Lite write-side responder: terminates the AW, W and B channels of a valid/ready write interface and drives a simple register-bank write port. AW and W are accepted independently and in either order; each completed pair produces exactly one register write and one B response. It sits at the subordinate end of a write path, downstream of any register slices on AW/W and upstream of them on B.

## Interface
- ADDR_W, 12: byte address width; word index is addr[ADDR_W-1:2].
- DATA_W, 32: data width; must be a multiple of 8.
- REG_NUM, 16: number of implemented words, indices 0..REG_NUM-1; must be ≤ 2^(ADDR_W-2).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_awvalid  in  1  write address valid.
- s_awready  out  1  write address ready.
- s_awaddr  in  ADDR_W  byte address.
- s_wvalid  in  1  write data valid.
- s_wready  out  1  write data ready.
- s_wdata  in  DATA_W  write data.
- s_wstrb  in  DATA_W/8  byte strobes.
- s_bvalid  out  1  response valid.
- s_bready  in  1  response ready.
- s_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- reg_wr_en  out  1  one-cycle register write pulse.
- reg_wr_addr  out  ADDR_W-2  word index.
- reg_wr_data  out  DATA_W  write data.
- reg_wr_strb  out  DATA_W/8  byte enables.

## Operation
- Two one-entry holding registers: AW (flag + addr), W (flag + data + strb). s_awready = ~aw_full & init_done; s_wready = ~w_full & init_done.
- AW handshake (awvalid & awready) loads the AW holder; W handshake likewise. The two are fully independent; either may arrive first or both in the same cycle.
- FSM states: IDLE (no B outstanding), RESP (s_bvalid high).
- Commit condition: aw_full & w_full & (state==IDLE | s_bready). On commit edge: both holders clear; reg_wr_* registered from holders with reg_wr_en=1 (unless suppressed by error); s_bvalid=1, s_bresp loaded; state→RESP.
- RESP & s_bready & no commit → IDLE, s_bvalid=0. RESP & s_bready & commit → stays RESP with new response (back-to-back B).
- Holders may fill while in RESP; they stall (ready low) until commit.
- s_bvalid, s_bresp stable while s_bvalid & ~s_bready.
- Low two address bits ignored; no unaligned handling.
- reg_wr_en never asserts except on a commit; never more than once per B.

## Timing
- Reset: s_awready=0, s_wready=0, s_bvalid=0, s_bresp=2'b00, reg_wr_en=0, reg_wr_addr/data/strb=0, holders empty, state IDLE, init_done=0.
- init_done sets on first rising edge after rst deasserts; readies are high from the next cycle.
- Latency: AW and W handshakes both in cycle N → holders full in N+1 → reg_wr_en and s_bvalid high in N+2; s_awready/s_wready high again in N+2.
- Sustained throughput with s_bready tied high: one write per 2 cycles.
- rst asserted mid-transaction: held AW/W discarded, pending B dropped, no reg_wr_en issued.

## Configuration
- AXIL_WR_RESP_SLVERR_EN defined: word index ≥ REG_NUM gives s_bresp=2'b10 and reg_wr_en stays 0 for that commit (reg_wr_addr/data/strb may update).
- Undefined: no range check; s_bresp always 2'b00, every commit pulses reg_wr_en, index passed through unmodified.

## Structure
- Package axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, FSM state encoding (IDLE, RESP).
- Sub-module axil_hold_reg (parameter W): one-entry holder with load/clear and full flag; instantiated for AW (ADDR_W) and W (DATA_W + DATA_W/8).

## Test plan
- AW addr 0x008 and W data 0xDEADBEEF strb 4'hF same cycle N, bready=1 → reg_wr_en in N+2, reg_wr_addr=2, data 0xDEADBEEF, bresp OKAY, bvalid one cycle.
- W (0x12345678, strb 4'h3) 3 cycles before AW 0x004 → wready low after W accepted; single write to index 1 with strb 4'h3 two cycles after AW handshake.
- bready held low 5 cycles with two writes offered → second pair held, readies low, bvalid/bresp stable; second reg_wr_en in cycle after bready rises; exactly two B and two writes.
- With macro, AW 0x040 (index 16, REG_NUM=16) → bresp 2'b10, no reg_wr_en; without macro → OKAY and reg_wr_en with index 16.
- 20 back-to-back writes, bready=1, random AW/W skew ≤3 cycles → 20 writes, 20 B, in order, no duplicates.
- rst asserted with AW held and bvalid high → all outputs reset values asynchronously; no reg_wr_en after release; readies high second cycle after release.
